// File: rtl/gray2bin_sync_decoder.sv
// Synchronises a Gray-coded count into clk, decodes it to binary and classifies
// each change as an up step, a down step or an illegal jump (counted, saturating).
module gray2bin_sync_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             clr_err,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             dir_up,
    output logic             step_err,
    output logic [7:0]       err_cnt,
    output logic             ready
);

    localparam logic [0:0]       ST_INIT   = 1'b0;
    localparam logic [0:0]       ST_RUN    = 1'b1;
    localparam logic [2:0]       INIT_LAST = 3'(SYNC_STAGES);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] g_s, nb, bin_inc, bin_dec;
    logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
    logic [WIDTH-1:0] bin_out_q, bin_out_d;
    logic [2:0]       init_cnt_q, init_cnt_d;
    logic [0:0]       state_q, state_d;
    logic             bin_valid_q, bin_valid_d;
    logic             dir_up_q, dir_up_d;
    logic             step_err_q, step_err_d;
    logic             ready_q, ready_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    always_comb begin
        sync_d[0] = gray_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign g_s = sync_q[SYNC_STAGES-1];

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        logic acc;
        acc = 1'b0;
        nb  = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc   = acc ^ g_s[i];
            nb[i] = acc;
        end
    end

    assign bin_inc = bin_out_q + ONE;
    assign bin_dec = bin_out_q - ONE;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        prev_gray_d = prev_gray_q;
        bin_out_d   = bin_out_q;
        dir_up_d    = dir_up_q;
        ready_d     = ready_q;
        bin_valid_d = 1'b0;
        step_err_d  = 1'b0;
        err_cnt_d   = clr_err ? 8'd0 : err_cnt_q;
        case (state_q)
            ST_INIT: begin
                // Wait for the synchroniser to fill before trusting g_s.
                if (init_cnt_q == INIT_LAST) begin
                    prev_gray_d = g_s;
                    bin_out_d   = nb;
                    bin_valid_d = 1'b1;
                    ready_d     = 1'b1;
                    state_d     = ST_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + 3'd1;
                end
            end
            ST_RUN: begin
                if (g_s != prev_gray_q) begin
                    prev_gray_d = g_s;
                    bin_out_d   = nb;
                    bin_valid_d = 1'b1;
                    if (nb == bin_inc) begin
                        dir_up_d = 1'b1;
                    end else if (nb == bin_dec) begin
                        dir_up_d = 1'b0;
                    end else begin
                        step_err_d = 1'b1;
                        if (clr_err) begin
                            err_cnt_d = 8'd1;
                        end else if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            prev_gray_q <= '0;
            bin_out_q   <= '0;
            bin_valid_q <= 1'b0;
            dir_up_q    <= 1'b0;
            step_err_q  <= 1'b0;
            ready_q     <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            prev_gray_q <= prev_gray_d;
            bin_out_q   <= bin_out_d;
            bin_valid_q <= bin_valid_d;
            dir_up_q    <= dir_up_d;
            step_err_q  <= step_err_d;
            ready_q     <= ready_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bin_out   = bin_out_q;
    assign bin_valid = bin_valid_q;
    assign dir_up    = dir_up_q;
    assign step_err  = step_err_q;
    assign err_cnt   = err_cnt_q;
    assign ready     = ready_q;

endmodule

// File: tb/tb_gray2bin_sync_decoder.sv
// Directed bench for gray2bin_sync_decoder: a binary-domain model pushes each
// expected decode (value, direction, error, arrival cycle) and a monitor pops it.
module tb_gray2bin_sync_decoder;

    localparam int W   = 4;
    localparam int S   = 2;
    localparam int LAT = S + 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clr_err = 1'b0;
    logic [W-1:0] gray_in = '0;
    logic [W-1:0] bin_out;
    logic         bin_valid, dir_up, step_err, ready;
    logic [7:0]   err_cnt;

    gray2bin_sync_decoder #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .gray_in  (gray_in),
        .clr_err  (clr_err),
        .bin_out  (bin_out),
        .bin_valid(bin_valid),
        .dir_up   (dir_up),
        .step_err (step_err),
        .err_cnt  (err_cnt),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] bin;
        logic         dir;
        logic         err;
        int           at;
    } exp_t;

    exp_t         sb[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           pulses  = 0;
    logic [W-1:0] m_bin   = '0;
    logic         m_dir   = 1'b0;
    int           m_errs  = 0;
    int           p0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: every bin_valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n === 1'b1) begin
            check("step_err_without_valid", {31'd0, step_err & ~bin_valid}, 32'd0);
            if (bin_valid) begin
                pulses++;
                check("pending_on_valid", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("pulse_bin_out",  {28'd0, bin_out},  {28'd0, e.bin});
                    check("pulse_dir_up",   {31'd0, dir_up},   {31'd0, e.dir});
                    check("pulse_step_err", {31'd0, step_err}, {31'd0, e.err});
                    check("pulse_cycle",    cyc,               e.at);
                end
            end
        end
    end

    task automatic drive(input logic [W-1:0] nb, input int hold);
        exp_t         e;
        logic [W-1:0] up, dn;
        @(negedge clk);
        if (nb != m_bin) begin
            up    = m_bin + 4'd1;
            dn    = m_bin - 4'd1;
            e.bin = nb;
            e.err = 1'b0;
            e.at  = cyc + LAT;
            if (nb == up) m_dir = 1'b1;
            else if (nb == dn) m_dir = 1'b0;
            else begin
                e.err = 1'b1;
                if (m_errs < 255) m_errs++;
            end
            e.dir = m_dir;
            m_bin = nb;
            sb.push_back(e);
        end
        gray_in = nb ^ (nb >> 1);
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic release_rst(input logic [W-1:0] init_bin);
        exp_t e;
        @(negedge clk);
        rst_n  = 1'b1;
        e.bin  = init_bin;
        e.dir  = 1'b0;
        e.err  = 1'b0;
        e.at   = cyc + LAT;
        m_bin  = init_bin;
        m_dir  = 1'b0;
        m_errs = 0;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 12 && sb.size() != 0; i++) @(negedge clk);
        check(tag, sb.size(), 32'd0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish by 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bin_out",   {28'd0, bin_out},   32'd0);
        check("rst_bin_valid", {31'd0, bin_valid}, 32'd0);
        check("rst_dir_up",    {31'd0, dir_up},    32'd0);
        check("rst_step_err",  {31'd0, step_err},  32'd0);
        check("rst_err_cnt",   {24'd0, err_cnt},   32'd0);
        check("rst_ready",     {31'd0, ready},     32'd0);

        // Init: ready rises on the third edge after release
        release_rst(4'd0);
        repeat (2) @(negedge clk);
        check("init_ready_early", {31'd0, ready}, 32'd0);
        @(negedge clk);
        check("init_ready",   {31'd0, ready},   32'd1);
        check("init_err_cnt", {24'd0, err_cnt}, 32'd0);
        drain("init_drain");

        // Full up walk including 15 -> 0 wrap
        p0 = pulses;
        for (int b = 1; b <= 16; b++) drive(4'(b), 4);
        drain("walk_drain");
        check("walk_pulses",  pulses - p0,         32'd16);
        check("walk_bin_out", {28'd0, bin_out},    32'd0);
        check("walk_dir_up",  {31'd0, dir_up},     32'd1);
        check("walk_err_cnt", {24'd0, err_cnt},    32'd0);

        // Down steps from 5
        for (int b = 1; b <= 5; b++) drive(4'(b), 4);
        drive(4'd4, 4);
        drive(4'd3, 4);
        drain("down_drain");
        check("down_bin_out", {28'd0, bin_out}, 32'd3);
        check("down_dir_up",  {31'd0, dir_up},  32'd0);

        // Illegal jumps, direction held
        drive(4'd2, 4); drive(4'd1, 4); drive(4'd0, 4);
        drive(4'd3, 4);
        drain("jump_drain");
        check("jump_err_cnt", {24'd0, err_cnt}, 32'd1);
        check("jump_bin_out", {28'd0, bin_out}, 32'd3);
        check("jump_dir_up",  {31'd0, dir_up},  32'd0);
        drive(4'd4, 4);
        drive(4'd7, 4);
        drain("jump2_drain");
        check("jump2_err_cnt", {24'd0, err_cnt}, 32'd2);
        check("jump2_dir_up",  {31'd0, dir_up},  32'd1);

        for (int i = 0; i < 300; i++) drive((i % 2) ? 4'd8 : 4'd0, 1);
        drain("sat_drain");
        check("sat_err_cnt", {24'd0, err_cnt}, 32'd255);

        // clr_err on the same edge that evaluates an error
        drive(4'd2, 1);
        repeat (2) @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_errs  = 1;
        check("clr_with_err", {24'd0, err_cnt}, m_errs);
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("clr_alone", {24'd0, err_cnt}, 32'd0);
        drain("clr_drain");

        // Back-to-back legal steps, one per cycle
        p0 = pulses;
        for (int i = 1; i <= 20; i++) drive(4'((2 + i) % 16), 1);
        drain("b2b_drain");
        check("b2b_pulses",  pulses - p0,      32'd20);
        check("b2b_bin_out", {28'd0, bin_out}, 32'd6);

        // Jump to 9, then reset mid-operation
        drive(4'd9, 1);
        drain("pre_rst_drain");
        check("pre_rst_bin_out", {28'd0, bin_out}, 32'd9);
        check("pre_rst_err_cnt", {24'd0, err_cnt}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_bin_out", {28'd0, bin_out}, 32'd0);
        check("mid_rst_dir_up",  {31'd0, dir_up},  32'd0);
        check("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("mid_rst_ready",   {31'd0, ready},   32'd0);
        gray_in = 4'd12 ^ (4'd12 >> 1);
        release_rst(4'd12);
        repeat (2) @(negedge clk);
        check("reinit_ready_early", {31'd0, ready}, 32'd0);
        drain("reinit_drain");
        check("reinit_bin_out", {28'd0, bin_out}, 32'd12);
        check("reinit_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("reinit_ready",   {31'd0, ready},   32'd1);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gray2bin_sync_decoder.md
Name: gray2bin_sync_decoder

Overview:
Receive-side counterpart of the team's binary-to-Gray encoder. It takes a Gray-coded count from another clock domain or an external source, typically a FIFO pointer or a position encoder. It synchronises the count into clk, decodes it to binary, and reports each step as up or down. It flags and counts illegal jumps, meaning any change that is not exactly one binary step.

Parameters:
WIDTH, 4, bit width of the Gray and binary values (legal range 2..16)
SYNC_STAGES, 2, number of synchroniser flops on gray_in (legal range 2..4)

Ports:
clk  input  1  system clock; all logic is rising-edge
rst_n  input  1  asynchronous active-low reset; assertion is immediate, release is synchronous to the design
gray_in  input  WIDTH  Gray-coded count; asynchronous to clk
clr_err  input  1  synchronous clear of err_cnt
bin_out  output  WIDTH  registered binary decode of the last accepted value
bin_valid  output  1  one-cycle pulse when bin_out is loaded or changes
dir_up  output  1  direction of the last accepted step: 1 = +1, 0 = -1; updated only on legal steps
step_err  output  1  one-cycle pulse on an illegal jump
err_cnt  output  8  count of illegal jumps; saturates at 255
ready  output  1  high once the INIT state has completed

Behaviour:
- Reset state:
  - Sync chain, prev_gray, bin_out, err_cnt and the init counter are all 0.
  - bin_valid, step_err, dir_up and ready are all 0.
  - FSM is in ST_INIT.
- Synchroniser:
  - gray_in passes through SYNC_STAGES flops; the last stage is g_s.
  - There is no combinational path from gray_in to any output.
- Decode: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] XOR g[i]. Decode is combinational on g_s and registered into bin_out.
- ST_INIT:
  - Count SYNC_STAGES edges after reset release so the chain fills.
  - On the following edge: load prev_gray <= g_s and bin_out <= decode(g_s). Pulse bin_valid, set ready=1, go to ST_RUN.
  - No error check is done on this load.
- ST_RUN, evaluated each edge with nb = decode(g_s):
  - g_s == prev_gray: hold all outputs; bin_valid=0, step_err=0.
  - nb == bin_out+1 mod 2^WIDTH: update bin_out and prev_gray, bin_valid=1, dir_up=1.
  - nb == bin_out-1 mod 2^WIDTH: update bin_out and prev_gray, bin_valid=1, dir_up=0.
  - Any other change: update bin_out and prev_gray (resynchronise to the new value), bin_valid=1, step_err=1, dir_up held, err_cnt incremented.
- Wrap-around:
  - All-ones to 0 is a legal +1 step; 0 to all-ones is a legal -1 step.
  - For WIDTH=4: Gray 1000 to 0000 gives dir_up=1.
- Latency: a change on gray_in that is stable before edge n appears on bin_out and bin_valid after edge n+SYNC_STAGES. For SYNC_STAGES=2 that is 3 edges.
- err_cnt:
  - Saturates at 255; further errors still pulse step_err.
  - clr_err sets err_cnt to 0 at the next edge.
  - If clr_err coincides with an error, err_cnt becomes 1.
- Reset mid-operation: on rst_n low all state returns immediately to reset values. After release, the full INIT sequence is repeated.
- Back-to-back legal steps, one per cycle, each produce a bin_valid pulse. No steps are dropped and no backpressure exists.

Test Plan:
1. Reset, gray_in=0000, SYNC_STAGES=2 -> ready rises 3 edges after release; bin_out=0, bin_valid pulses once, err_cnt=0.
2. Walk gray_in through the full up sequence 0000,0001,0011,...,1000, then 0000, one value every 4 cycles -> bin_out goes 0..15 then 0; 16 bin_valid pulses; dir_up=1 throughout; step_err never asserts.
3. From bin_out=5 (gray 0111), apply gray 0110 and then 0010 -> bin_out=4 then 3, dir_up=0.
4. From bin_out=0, apply gray 0010 (binary 3) -> step_err pulses once, bin_out=3, err_cnt=1, dir_up unchanged. Then inject 300 illegal jumps -> err_cnt=255. Then assert clr_err coincident with one more error -> err_cnt=1.
5. Change gray_in every cycle through the legal up sequence -> bin_out tracks with a 3-cycle delay and a bin_valid pulse every cycle.
6. Assert rst_n low for 1 cycle while bin_out=9 -> all outputs are 0 immediately; after release, INIT repeats and bin_out reloads from the current gray_in with no step_err.
